// File: rtl/qlog2_pkg.sv
// rtl/qlog2_pkg.sv - shared FSM type, default sizes and zero-operand result helper for qlog2_seq
package qlog2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } qlog2_state_e;

  localparam int unsigned QLOG2_W = 32;
  localparam int unsigned QLOG2_F = 16;

  // Most negative w-bit two's-complement value (MSB set, rest zero); valid for w <= 64.
  function automatic logic [63:0] qlog2_err_word(input int unsigned w);
    qlog2_err_word = 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/qlog2_lod.sv
// rtl/qlog2_lod.sv - combinational leading-one detector: MSB index of din plus a zero flag
module qlog2_lod
  import qlog2_pkg::*;
#(
  parameter int unsigned W  = QLOG2_W,
  localparam int unsigned IW = $clog2(W)
) (
  input  logic [W-1:0]  din,
  output logic [IW-1:0] msb_idx,
  output logic          zero
);

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (din[i]) msb_idx = IW'(i);
    end
    zero = (din == '0);
  end

endmodule

// File: rtl/qlog2_seq.sv
// rtl/qlog2_seq.sv - sequential Q(W-F).F log2 by repeated squaring; QLOG2_ROUND_EN adds a rounding iteration
module qlog2_seq
  import qlog2_pkg::*;
#(
  parameter int unsigned W = QLOG2_W,
  parameter int unsigned F = QLOG2_F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned KW = W - F;
  localparam int unsigned SW = 2 * F + 2;
`ifdef QLOG2_ROUND_EN
  localparam int unsigned NI = F + 1;
`else
  localparam int unsigned NI = F;
`endif
  localparam int unsigned CW = $clog2(NI);
  localparam logic [63:0] ERR_FULL = qlog2_err_word(W);

  qlog2_state_e          state_q, state_d;
  logic [W-1:0]          opnd_q, opnd_d;
  logic [F+1:0]          y_q, y_d;
  logic signed [KW-1:0]  k_q, k_d;
  logic [NI-1:0]         frac_q, frac_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_data_q, out_data_d;
  logic                  out_err_q, out_err_d;

  logic [IW-1:0]         msb_idx;
  logic                  opnd_zero;
  logic [W-1:0]          norm_val;
  logic [SW-1:0]         sq;
  logic [F+1:0]          kept;
  logic                  frac_bit;
  logic [NI-1:0]         frac_nxt;
  logic [F-1:0]          frac_out;
  logic signed [KW-1:0]  k_out;
  logic                  last_iter;
  logic                  unused_bits;
`ifdef QLOG2_ROUND_EN
  logic [F:0]            rnd;
`endif

  qlog2_lod #(.W(W)) u_lod (
    .din     (opnd_q),
    .msb_idx (msb_idx),
    .zero    (opnd_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      y_q         <= '0;
      k_q         <= '0;
      frac_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      y_q         <= y_d;
      k_q         <= k_d;
      frac_q      <= frac_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready_q) state_d = NORM;
      NORM:    state_d = opnd_zero ? DONE : ITER;
      ITER:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they are low throughout reset.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_comb begin
    last_iter = (cnt_q == CW'(NI - 1));
    if (msb_idx >= IW'(F)) norm_val = opnd_q >> (msb_idx - IW'(F));
    else                   norm_val = opnd_q << (IW'(F) - msb_idx);

    // y < 2.0 so y*y < 4.0 fits in 2F+2 bits; keeping [2F+1:F] truncates back to Q2.F.
    sq       = SW'(y_q) * SW'(y_q);
    kept     = sq[2*F+1:F];
    frac_bit = kept[F+1];
    frac_nxt = {frac_q[NI-2:0], frac_bit};
`ifdef QLOG2_ROUND_EN
    rnd      = {1'b0, frac_nxt[NI-1:1]} + {{F{1'b0}}, frac_nxt[0]};
    frac_out = rnd[F-1:0];
    k_out    = k_q + KW'(rnd[F]);
`else
    frac_out = frac_nxt;
    k_out    = k_q;
`endif

    opnd_d     = opnd_q;
    y_d        = y_q;
    k_d        = k_q;
    frac_d     = frac_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: if (in_valid && in_ready_q) opnd_d = in_data;
      NORM: begin
        k_d    = KW'(msb_idx) - KW'(F);
        y_d    = norm_val[F+1:0];
        frac_d = '0;
        cnt_d  = '0;
        if (opnd_zero) begin
          out_err_d  = 1'b1;
          out_data_d = ERR_FULL[W-1:0];
        end
      end
      ITER: begin
        y_d    = frac_bit ? (kept >> 1) : kept;
        frac_d = frac_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (last_iter) begin
          out_err_d  = 1'b0;
          out_data_d = {k_out, frac_out};
        end
      end
      default: ;
    endcase
  end

  assign unused_bits = ^{sq[F-1:0], norm_val[W-1:F+2], frac_q[NI-1]};

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_qlog2_seq.sv
// tb/tb_qlog2_seq.sv - scoreboard bench for qlog2_seq: powers of two, fractions, zero, back-pressure, reset, streaming
module tb_qlog2_seq;

`ifdef QLOG2_ROUND_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 18;
`endif
  localparam int GAP = LAT + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  qlog2_seq #(.W(32), .F(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // Reference: normalise by scanning for the top one, then square/compare/halve in wide integers.
  function automatic exp_t model(input logic [31:0] x);
    exp_t        e;
    longint      y;
    int          p;
    int          k;
    logic [31:0] frac;
    int          nbits;
    if (x == 32'd0) begin
      e.data = 32'h8000_0000;
      e.err  = 1'b1;
      return e;
    end
    p = 31;
    while (!x[p]) p--;
    k = p - 16;
    if (p >= 16) y = longint'(x) >> (p - 16);
    else         y = longint'(x) << (16 - p);
`ifdef QLOG2_ROUND_EN
    nbits = 17;
`else
    nbits = 16;
`endif
    frac = '0;
    for (int i = 0; i < nbits; i++) begin
      y = (y * y) >> 16;
      if (y >= 64'd131072) begin
        frac = (frac << 1) | 32'd1;
        y = y >> 1;
      end else begin
        frac = frac << 1;
      end
    end
`ifdef QLOG2_ROUND_EN
    frac = (frac >> 1) + (frac & 32'd1);
    if (frac[16]) begin
      k++;
      frac = '0;
    end
`endif
    e.data = {k[15:0], frac[15:0]};
    e.err  = 1'b0;
    return e;
  endfunction

  // Offer x and return just after the accepting edge; ok=0 if in_ready never came.
  task automatic send(input logic [31:0] x, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    in_valid = 1'b1;
    in_data  = x;
    sb.push_back(model(x));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accepting edge (cycle after it is 1) until out_valid, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] x, output logic [31:0] got, output logic gerr,
                       output int cyc, output bit ok, output exp_t e);
    send(x, ok);
    wait_valid(cyc);
    got  = out_data;
    gerr = out_err;
    e    = sb.pop_front();
    consume();
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 32'd0)  begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_checks++; if (out_err !== 1'b0)    begin n_fail++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_powers;
    logic [31:0] ops [6] = '{32'h0001_0000, 32'h0004_0000, 32'h0000_0001,
                             32'h0000_8000, 32'h0008_0000, 32'h8000_0000};
    logic [31:0] want[6] = '{32'h0000_0000, 32'h0002_0000, 32'hFFF0_0000,
                             32'hFFFF_0000, 32'h0003_0000, 32'h000F_0000};
    logic [31:0] got;
    logic        gerr;
    int          cyc;
    bit          ok;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], got, gerr, cyc, ok, e);
      n_checks++; if (!ok)          begin n_fail++; $display("FAIL pow_accept op=%h in_ready never high", ops[i]); end
      n_checks++; if (got !== want[i]) begin n_fail++; $display("FAIL pow_data op=%h got=%h exp=%h", ops[i], got, want[i]); end
      n_checks++; if (got !== e.data)  begin n_fail++; $display("FAIL pow_model op=%h got=%h exp=%h", ops[i], got, e.data); end
      n_checks++; if (gerr !== 1'b0)   begin n_fail++; $display("FAIL pow_err op=%h got=%b exp=0", ops[i], gerr); end
      n_checks++; if (cyc != LAT)      begin n_fail++; $display("FAIL pow_latency op=%h got=%0d exp=%0d", ops[i], cyc, LAT); end
    end
  endtask

  task automatic test_fraction;
    logic [31:0] got;
    logic [31:0] x;
    logic        gerr;
    int          cyc;
    int          diff;
    bit          ok;
    exp_t        e;
    do_op(32'h0001_8000, got, gerr, cyc, ok, e);
    diff = int'(got) - 32'h95C0;
    n_checks++; if (got !== e.data)        begin n_fail++; $display("FAIL frac15_model got=%h exp=%h", got, e.data); end
    n_checks++; if (diff > 2 || diff < -2) begin n_fail++; $display("FAIL frac15_near got=%h exp=0000_95c0+-2", got); end
    n_checks++; if (got[15:12] !== 4'b1001) begin n_fail++; $display("FAIL frac15_topbits got=%b exp=1001", got[15:12]); end
    n_checks++; if (gerr !== 1'b0)         begin n_fail++; $display("FAIL frac15_err got=%b exp=0", gerr); end
    for (int i = 0; i < 4; i++) begin
      x = $urandom | 32'd1;
      x = x >> $urandom_range(0, 31);
      do_op(x, got, gerr, cyc, ok, e);
      n_checks++; if (got !== e.data || gerr !== e.err)
        begin n_fail++; $display("FAIL frac_rand op=%h got=%h/%b exp=%h/%b", x, got, gerr, e.data, e.err); end
    end
  endtask

  task automatic test_zero;
    logic [31:0] got;
    logic        gerr;
    int          cyc;
    bit          ok;
    exp_t        e;
    do_op(32'd0, got, gerr, cyc, ok, e);
    n_checks++; if (got !== 32'h8000_0000) begin n_fail++; $display("FAIL zero_data got=%h exp=80000000", got); end
    n_checks++; if (gerr !== 1'b1)         begin n_fail++; $display("FAIL zero_err got=%b exp=1", gerr); end
    n_checks++; if (cyc != 2)              begin n_fail++; $display("FAIL zero_latency got=%0d exp=2", cyc); end
    n_checks++; if (got !== e.data)        begin n_fail++; $display("FAIL zero_model got=%h exp=%h", got, e.data); end
  endtask

  task automatic test_backpressure;
    int   cyc;
    bit   ok;
    exp_t e;
    send(32'h0003_0000, ok);
    wait_valid(cyc);
    e = sb.pop_front();
    in_valid = 1'b1;
    in_data  = 32'h0010_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== e.data || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h r=%b exp v=1 d=%h r=0", i, out_valid, out_data, in_ready, e.data); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
    sb.push_back(model(32'h0010_0000));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got r=%b exp 0", in_ready); end
    wait_valid(cyc);
    e = sb.pop_front();
    n_checks++; if (out_data !== 32'h0004_0000 || out_data !== e.data || cyc != LAT)
      begin n_fail++; $display("FAIL bp_next_data got=%h lat=%0d exp=00040000 lat=%0d", out_data, cyc, LAT); end
    consume();
  endtask

  task automatic test_reset_mid_iter;
    logic [31:0] got;
    logic        gerr;
    int          cyc;
    int          nv = 0;
    bit          ok;
    exp_t        e;
    send(32'h0005_0000, ok);
    void'(sb.pop_back());
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_err !== 1'b0)
      begin n_fail++; $display("FAIL midrst_clear got r=%b v=%b d=%h e=%b exp all 0", in_ready, out_valid, out_data, out_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    n_checks++; if (nv != 0) begin n_fail++; $display("FAIL midrst_no_valid got=%0d pulses exp=0", nv); end
    do_op(32'h0008_0000, got, gerr, cyc, ok, e);
    n_checks++; if (got !== 32'h0003_0000 || gerr !== 1'b0 || cyc != LAT)
      begin n_fail++; $display("FAIL midrst_after got=%h/%b lat=%0d exp=00030000/0 lat=%0d", got, gerr, cyc, LAT); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ops[4] = '{32'h0002_4000, 32'h1234_5678, 32'h0000_0003, 32'h7FFF_FFFF};
    int   nacc = 0;
    int   ndone = 0;
    int   cyc = 0;
    int   last_acc = -1;
    exp_t e;
    out_ready = 1'b1;
    @(negedge clk);
    while (ndone < 4 && cyc < 300) begin
      in_valid = (nacc < 4);
      in_data  = ops[nacc < 4 ? nacc : 0];
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        if (last_acc >= 0) begin
          n_checks++; if (cyc - last_acc != GAP)
            begin n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", cyc - last_acc, GAP); end
        end
        last_acc = cyc;
        nacc++;
      end
      if (out_valid) begin
        e = sb.pop_front();
        n_checks++; if (out_data !== e.data || out_err !== e.err)
          begin n_fail++; $display("FAIL b2b_data idx=%0d got=%h/%b exp=%h/%b", ndone, out_data, out_err, e.data, e.err); end
        ndone++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (ndone != 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", ndone); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_powers();
    test_fraction();
    test_zero();
    test_backpressure();
    test_reset_mid_iter();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
